// File: rtl/rom_download_ctrl.sv
// Sequences the SD-card ROM image download into the per-chip ROM port B,
// checks addressing and byte count, and holds the game CPU in reset until a good image is loaded.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | no download seen since reset
// S_LOAD    | accepting ioctl writes for the game ROM index
// S_CHECK   | one cycle after download end; verify count and error latch
// S_RELEASE | image good; count down before releasing the CPU
// S_DONE    | image loaded and verified, CPU running
// S_ERROR   | last load failed; CPU held, error code frozen
module rom_download_ctrl #(
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter logic [24:0] TOTAL_SIZE  = 25'hD240,
    parameter int          HOLD_CYCLES = 16
) (
    input  logic        i_clk_dl,
    input  logic        i_reset,
    input  logic        i_ioctl_download,
    input  logic [7:0]  i_ioctl_index,
    input  logic        i_ioctl_wr,
    input  logic [24:0] i_ioctl_addr,
    input  logic [7:0]  i_ioctl_data,
    output logic [24:0] o_addr_dl,
    output logic [7:0]  o_data_dl,
    output logic        o_wr_dl,
    output logic [10:0] o_cs_dl,
    output logic [10:0] o_region_seen,
    output logic        o_cpu_hold,
    output logic        o_load_done,
    output logic        o_load_err,
    output logic [1:0]  o_err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RELEASE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_dl_prev;
    logic [24:0]   r_byte_cnt;
    logic [24:0]   r_exp_addr;
    logic [15:0]   r_hold_cnt;
    logic [24:0]   r_addr_dl;
    logic [7:0]    r_data_dl;
    logic          r_wr_dl;
    logic [10:0]   r_cs_dl;
    logic [10:0]   r_region_seen;
    logic          r_cpu_hold;
    logic          r_load_done;
    logic          r_load_err;
    logic [1:0]    r_err_code;

    logic          w_start;
    logic          w_fall;
    logic          w_in_range;
    logic          w_image_ok;
    logic [10:0]   w_cs;

    assign w_start    = i_ioctl_download && !r_dl_prev && (i_ioctl_index == ROM_INDEX);
    assign w_fall     = !i_ioctl_download && r_dl_prev;
    assign w_in_range = i_ioctl_addr < TOTAL_SIZE;
    assign w_image_ok = (r_byte_cnt == TOTAL_SIZE) && (r_err_code == 2'b00);

    // Half-open region ranges; anything past cp2 selects nothing.
    always_comb begin
        w_cs = 11'h000;
        if      (i_ioctl_addr < 25'h02000) w_cs = 11'h001;
        else if (i_ioctl_addr < 25'h04000) w_cs = 11'h002;
        else if (i_ioctl_addr < 25'h06000) w_cs = 11'h004;
        else if (i_ioctl_addr < 25'h08000) w_cs = 11'h008;
        else if (i_ioctl_addr < 25'h0A000) w_cs = 11'h010;
        else if (i_ioctl_addr < 25'h0C000) w_cs = 11'h020;
        else if (i_ioctl_addr < 25'h0D000) w_cs = 11'h040;
        else if (i_ioctl_addr < 25'h0D100) w_cs = 11'h080;
        else if (i_ioctl_addr < 25'h0D200) w_cs = 11'h100;
        else if (i_ioctl_addr < 25'h0D220) w_cs = 11'h200;
        else if (i_ioctl_addr < 25'h0D240) w_cs = 11'h400;
    end

    always_ff @(posedge i_clk_dl or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_start) begin
            w_next = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD:    if (w_fall) w_next = S_CHECK;
                S_CHECK:   w_next = w_image_ok ? S_RELEASE : S_ERROR;
                S_RELEASE: if (r_hold_cnt == 16'd0) w_next = S_DONE;
                default:   w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk_dl or posedge i_reset) begin
        if (i_reset) begin
            r_dl_prev     <= 1'b0;
            r_byte_cnt    <= '0;
            r_exp_addr    <= '0;
            r_hold_cnt    <= '0;
            r_addr_dl     <= '0;
            r_data_dl     <= '0;
            r_wr_dl       <= 1'b0;
            r_cs_dl       <= '0;
            r_region_seen <= '0;
            r_cpu_hold    <= 1'b1;
            r_load_done   <= 1'b0;
            r_load_err    <= 1'b0;
            r_err_code    <= 2'b00;
        end else begin
            r_dl_prev <= i_ioctl_download;
            r_wr_dl   <= 1'b0;
            if (w_start) begin
                r_byte_cnt    <= '0;
                r_exp_addr    <= '0;
                r_region_seen <= '0;
                r_cpu_hold    <= 1'b1;
                r_load_done   <= 1'b0;
                r_load_err    <= 1'b0;
                r_err_code    <= 2'b00;
            end else begin
                case (r_state)
                    S_LOAD: begin
                        if (i_ioctl_wr) begin
                            if (!w_in_range) begin
                                r_cs_dl <= '0;
                                if (r_err_code == 2'b00) r_err_code <= 2'b10;
                            end else begin
                                r_addr_dl     <= i_ioctl_addr;
                                r_data_dl     <= i_ioctl_data;
                                r_cs_dl       <= w_cs;
                                r_wr_dl       <= 1'b1;
                                r_region_seen <= r_region_seen | w_cs;
                                r_exp_addr    <= i_ioctl_addr + 25'd1;
                                if (r_byte_cnt != '1) r_byte_cnt <= r_byte_cnt + 25'd1;
                                // Out-of-order bytes are still written; only the first fault is kept.
                                if ((i_ioctl_addr != r_exp_addr) && (r_err_code == 2'b00))
                                    r_err_code <= 2'b11;
                            end
                        end
                    end
                    S_CHECK: begin
                        r_hold_cnt <= HOLD_LOAD;
                        if (!w_image_ok) begin
                            r_load_err <= 1'b1;
                            r_cpu_hold <= 1'b1;
                            if (r_err_code == 2'b00) r_err_code <= 2'b01;
                        end
                    end
                    S_RELEASE: begin
                        if (r_hold_cnt == 16'd0) begin
                            r_cpu_hold  <= 1'b0;
                            r_load_done <= 1'b1;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_addr_dl     = r_addr_dl;
    assign o_data_dl     = r_data_dl;
    assign o_wr_dl       = r_wr_dl;
    assign o_cs_dl       = r_cs_dl;
    assign o_region_seen = r_region_seen;
    assign o_cpu_hold    = r_cpu_hold;
    assign o_load_done   = r_load_done;
    assign o_load_err    = r_load_err;
    assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_rom_download_ctrl.sv
// Directed bench for rom_download_ctrl: region decode table plus hand-built load sequences.
module tb_rom_download_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dl;
    logic [7:0]  idx;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  data;
    logic [24:0] addr_dl;
    logic [7:0]  data_dl;
    logic        wr_dl;
    logic [10:0] cs_dl;
    logic [10:0] seen;
    logic        cpu_hold;
    logic        done;
    logic        lerr;
    logic [1:0]  code;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rom_download_ctrl dut (
        .i_clk_dl        (clk),
        .i_reset         (rst),
        .i_ioctl_download(dl),
        .i_ioctl_index   (idx),
        .i_ioctl_wr      (wr),
        .i_ioctl_addr    (addr),
        .i_ioctl_data    (data),
        .o_addr_dl       (addr_dl),
        .o_data_dl       (data_dl),
        .o_wr_dl         (wr_dl),
        .o_cs_dl         (cs_dl),
        .o_region_seen   (seen),
        .o_cpu_hold      (cpu_hold),
        .o_load_done     (done),
        .o_load_err      (lerr),
        .o_err_code      (code)
    );

    typedef struct {
        logic [24:0] addr;
        logic        exp_wr;
        logic [10:0] exp_cs;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_wr(input logic [24:0] a);
        wr   = 1'b1;
        addr = a;
        data = a[7:0] ^ 8'h5A;
        step();
        wr = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] i);
        idx = i;
        dl  = 1'b1;
        step();
    endtask

    task automatic end_dl();
        dl = 1'b0;
        step();
        step();
    endtask

    task automatic stream(input int first, input int last, input int gap, input bit boundaries);
        int bad = 0;
        for (int a = first; a <= last; a++) begin
            do_wr(25'(a));
            if (wr_dl !== 1'b1 || addr_dl !== 25'(a) || data_dl !== (8'(a) ^ 8'h5A)) bad++;
            if (boundaries && a == 'h1FFF) chk("cs_at_1fff", 32'(cs_dl), 32'h001);
            if (boundaries && a == 'hD000) chk("cs_at_d000", 32'(cs_dl), 32'h080);
            if (boundaries && a == 'hD23F) chk("cs_at_d23f", 32'(cs_dl), 32'h400);
            for (int g = 0; g < gap; g++) begin
                step();
                if (wr_dl !== 1'b0) bad++;
            end
        end
        chk("stream_bad_writes", 32'(bad), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{25'h0000000, 1'b1, 11'h001};
        tbl[1]  = '{25'h0001FFF, 1'b1, 11'h001};
        tbl[2]  = '{25'h0002000, 1'b1, 11'h002};
        tbl[3]  = '{25'h0005FFF, 1'b1, 11'h004};
        tbl[4]  = '{25'h0006000, 1'b1, 11'h008};
        tbl[5]  = '{25'h0009FFF, 1'b1, 11'h010};
        tbl[6]  = '{25'h000BFFF, 1'b1, 11'h020};
        tbl[7]  = '{25'h000C000, 1'b1, 11'h040};
        tbl[8]  = '{25'h000CFFF, 1'b1, 11'h040};
        tbl[9]  = '{25'h000D000, 1'b1, 11'h080};
        tbl[10] = '{25'h000D0FF, 1'b1, 11'h080};
        tbl[11] = '{25'h000D100, 1'b1, 11'h100};
        tbl[12] = '{25'h000D1FF, 1'b1, 11'h100};
        tbl[13] = '{25'h000D200, 1'b1, 11'h200};
        tbl[14] = '{25'h000D21F, 1'b1, 11'h200};
        tbl[15] = '{25'h000D220, 1'b1, 11'h400};
        tbl[16] = '{25'h000D23F, 1'b1, 11'h400};
        tbl[17] = '{25'h000D240, 1'b0, 11'h000};
        tbl[18] = '{25'h1FFFFFF, 1'b0, 11'h000};

        rst = 1'b1; dl = 1'b0; idx = 8'd0; wr = 1'b0; addr = '0; data = '0;
        repeat (3) @(negedge clk);
        chk("rst_addr_dl", 32'(addr_dl), 32'd0);
        chk("rst_data_dl", 32'(data_dl), 32'd0);
        chk("rst_wr_dl", 32'(wr_dl), 32'd0);
        chk("rst_cs_dl", 32'(cs_dl), 32'd0);
        chk("rst_seen", 32'(seen), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(lerr), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        rst = 1'b0;
        step();

        // Region decode table on a deliberately non-sequential load.
        start_dl(8'd0);
        for (int i = 0; i < 19; i++) begin
            do_wr(tbl[i].addr);
            chk($sformatf("tbl%0d_wr_dl", i), 32'(wr_dl), 32'(tbl[i].exp_wr));
            chk($sformatf("tbl%0d_cs_dl", i), 32'(cs_dl), 32'(tbl[i].exp_cs));
            if (tbl[i].exp_wr) chk($sformatf("tbl%0d_addr_dl", i), 32'(addr_dl), 32'(tbl[i].addr));
            step();
            chk($sformatf("tbl%0d_wr_one_cycle", i), 32'(wr_dl), 32'd0);
        end
        chk("tbl_seen", 32'(seen), 32'h7FF);
        chk("tbl_code_live", 32'(code), 32'd3);
        end_dl();
        chk("tbl_err", 32'(lerr), 32'd1);
        chk("tbl_code", 32'(code), 32'd3);
        chk("tbl_cpu_hold", 32'(cpu_hold), 32'd1);

        // Short image: byte-count mismatch.
        start_dl(8'd0);
        chk("restart_err_clr", 32'(lerr), 32'd0);
        chk("restart_code_clr", 32'(code), 32'd0);
        chk("restart_seen_clr", 32'(seen), 32'd0);
        stream(0, 'h3FF, 1, 1'b0);
        end_dl();
        chk("short_err", 32'(lerr), 32'd1);
        chk("short_code", 32'(code), 32'd1);
        chk("short_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("short_seen", 32'(seen), 32'h001);
        chk("short_done", 32'(done), 32'd0);

        // Address beyond the image.
        start_dl(8'd0);
        stream(0, 'hFF, 0, 1'b0);
        do_wr(25'hD240);
        chk("oob_wr_dl", 32'(wr_dl), 32'd0);
        chk("oob_cs_dl", 32'(cs_dl), 32'd0);
        chk("oob_code_live", 32'(code), 32'd2);
        end_dl();
        chk("oob_code", 32'(code), 32'd2);
        chk("oob_err", 32'(lerr), 32'd1);
        chk("oob_cpu_hold", 32'(cpu_hold), 32'd1);

        // Skipped address 0x100; a later address fault keeps the first code.
        start_dl(8'd0);
        stream(0, 'hFF, 0, 1'b0);
        do_wr(25'h101);
        chk("skip_wr_dl", 32'(wr_dl), 32'd1);
        chk("skip_addr_dl", 32'(addr_dl), 32'h101);
        chk("skip_code_live", 32'(code), 32'd3);
        do_wr(25'hD240);
        chk("skip_code_after_oob", 32'(code), 32'd3);
        end_dl();
        chk("skip_code", 32'(code), 32'd3);
        chk("skip_err", 32'(lerr), 32'd1);

        // Asynchronous reset in the middle of a load.
        start_dl(8'd0);
        stream(0, 'h1FF, 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_dl", 32'(wr_dl), 32'd0);
        chk("mid_rst_addr_dl", 32'(addr_dl), 32'd0);
        chk("mid_rst_data_dl", 32'(data_dl), 32'd0);
        chk("mid_rst_cs_dl", 32'(cs_dl), 32'd0);
        chk("mid_rst_seen", 32'(seen), 32'd0);
        chk("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
        dl = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Full valid reload, one byte per cycle.
        start_dl(8'd0);
        stream(0, 'hD23F, 0, 1'b1);
        chk("full_seen", 32'(seen), 32'h7FF);
        chk("full_code_live", 32'(code), 32'd0);
        dl = 1'b0;
        repeat (17) step();
        chk("full_hold_before", 32'(cpu_hold), 32'd1);
        chk("full_done_before", 32'(done), 32'd0);
        step();
        chk("full_hold_release", 32'(cpu_hold), 32'd0);
        chk("full_done", 32'(done), 32'd1);
        chk("full_err", 32'(lerr), 32'd0);
        chk("full_code", 32'(code), 32'd0);

        // Foreign index is ignored and the good image stays loaded.
        start_dl(8'd1);
        do_wr(25'h0);
        chk("idx1_wr_dl", 32'(wr_dl), 32'd0);
        do_wr(25'h1);
        chk("idx1_wr_dl2", 32'(wr_dl), 32'd0);
        end_dl();
        chk("idx1_done", 32'(done), 32'd1);
        chk("idx1_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("idx1_err", 32'(lerr), 32'd0);
        chk("idx1_seen", 32'(seen), 32'h7FF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
